// File: rtl/refclk_freq_monitor_if.sv
// Control/status bundle between the refclk frequency monitor and its consumer
// (slow-control register file / link bring-up). 'slave' is the monitor side.
interface refclk_freq_monitor_if #(
    parameter int N_CLK = 16,
    parameter int CNT_W = 20
);
    logic [N_CLK-1:0] ref_tgl;
    logic [N_CLK-1:0] ch_mask;
    logic             clear_sticky;
    logic [4:0]       sel;
    logic [CNT_W-1:0] cnt_out;
    logic             meas_valid;
    logic [N_CLK-1:0] clk_ok;
    logic [N_CLK-1:0] clk_bad_sticky;
    logic             all_ok;

    modport master (
        output ref_tgl, ch_mask, clear_sticky, sel,
        input  cnt_out, meas_valid, clk_ok, clk_bad_sticky, all_ok
    );

    modport slave (
        input  ref_tgl, ch_mask, clear_sticky, sel,
        output cnt_out, meas_valid, clk_ok, clk_bad_sticky, all_ok
    );
endinterface

// File: rtl/refclk_freq_monitor.sv
// Counts divided-refclk toggle edges per fixed gate window of the fabric clock and
// flags channels whose count falls outside [EXP_MIN, EXP_MAX] (live and sticky).
module refclk_freq_monitor #(
    parameter int N_CLK       = 16,
    parameter int GATE_CYCLES = 125000,
    parameter int CNT_W       = 20,
    parameter int EXP_MIN     = 2495,
    parameter int EXP_MAX     = 2515
) (
    input logic                  clk,
    input logic                  rst,
    refclk_freq_monitor_if.slave bus
);
    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LIM_LO    = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0]  LIM_HI    = CNT_W'(EXP_MAX);

    generate
        if (EXP_MIN < 0 || EXP_MIN > EXP_MAX ||
            longint'(EXP_MAX) >= (longint'(1) << CNT_W)) begin : g_bad_limits
            $error("refclk_freq_monitor: need 0 <= EXP_MIN <= EXP_MAX < 2**CNT_W");
        end
    endgenerate

    logic [N_CLK-1:0]  s1_q, s2_q, s3_q;
    logic [N_CLK-1:0]  edge_det;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic              terminal;
    logic [CNT_W-1:0]  cnt_q    [N_CLK];
    logic [CNT_W-1:0]  cnt_d    [N_CLK];
    logic [CNT_W-1:0]  cnt_inc  [N_CLK];
    logic [CNT_W-1:0]  result_q [N_CLK];
    logic [CNT_W-1:0]  result_d [N_CLK];
    logic [N_CLK-1:0]  in_range;
    logic [N_CLK-1:0]  ok_q, ok_d;
    logic [N_CLK-1:0]  sticky_q, sticky_d;
    logic [N_CLK-1:0]  bad_set;
    logic              valid_q, valid_d;
    logic              all_ok_q, all_ok_d;
    logic [CNT_W-1:0]  cnt_out_q, cnt_out_d;

    // s1 is the metastability stage; edges are taken from the settled s2/s3 pair.
    assign edge_det = s2_q ^ s3_q;
    assign terminal = (gate_q == GATE_LAST);

    always_comb begin
        gate_d    = terminal ? '0 : gate_q + 1'b1;
        cnt_inc   = cnt_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        in_range  = '0;
        cnt_out_d = '0;
        for (int unsigned i = 0; i < N_CLK; i++) begin
            if (edge_det[i] && cnt_q[i] != '1) begin
                cnt_inc[i] = cnt_q[i] + 1'b1;
            end
            // The terminal-cycle edge is folded into the closing result only.
            cnt_d[i]    = terminal ? '0 : cnt_inc[i];
            result_d[i] = terminal ? cnt_inc[i] : result_q[i];
            in_range[i] = (cnt_inc[i] >= LIM_LO) && (cnt_inc[i] <= LIM_HI);
            if (32'(bus.sel) == i) begin
                cnt_out_d = result_q[i];
            end
        end
        ok_d     = terminal ? (bus.ch_mask | in_range) : ok_q;
        bad_set  = terminal ? (~bus.ch_mask & ~in_range) : '0;
        sticky_d = (bus.clear_sticky ? '0 : sticky_q) | bad_set;
        valid_d  = terminal;
        all_ok_d = &ok_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            gate_q    <= '0;
            ok_q      <= '0;
            sticky_q  <= '0;
            valid_q   <= 1'b0;
            all_ok_q  <= 1'b0;
            cnt_out_q <= '0;
            for (int unsigned i = 0; i < N_CLK; i++) begin
                cnt_q[i]    <= '0;
                result_q[i] <= '0;
            end
        end else begin
            s1_q      <= bus.ref_tgl;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            gate_q    <= gate_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            ok_q      <= ok_d;
            sticky_q  <= sticky_d;
            valid_q   <= valid_d;
            all_ok_q  <= all_ok_d;
            cnt_out_q <= cnt_out_d;
        end
    end

    assign bus.cnt_out        = cnt_out_q;
    assign bus.meas_valid     = valid_q;
    assign bus.clk_ok         = ok_q;
    assign bus.clk_bad_sticky = sticky_q;
    assign bus.all_ok         = all_ok_q;
endmodule

// File: tb/tb_refclk_freq_monitor.sv
// Randomized bench for refclk_freq_monitor: two instances (20-bit and saturating
// 8-bit counters) checked every cycle against a window-level reference model.
module tb_refclk_freq_monitor;
    localparam int N = 16;
    localparam int G = 1000;

    logic clk = 1'b0;
    logic rst;
    always #4 clk = ~clk;

    refclk_freq_monitor_if #(.N_CLK(N), .CNT_W(20)) ifa ();
    refclk_freq_monitor_if #(.N_CLK(N), .CNT_W(8))  ifb ();

    refclk_freq_monitor #(
        .N_CLK(N), .GATE_CYCLES(G), .CNT_W(20), .EXP_MIN(245), .EXP_MAX(255)
    ) u_dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    refclk_freq_monitor #(
        .N_CLK(N), .GATE_CYCLES(G), .CNT_W(8), .EXP_MIN(100), .EXP_MAX(200)
    ) u_dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int lo [2] = '{245, 100};
    int hi [2] = '{255, 200};
    int sat[2] = '{1048575, 255};

    // Sampled input levels per post-reset clock edge, {inst_b, inst_a}.
    logic [2*N-1:0] hist[$];
    int             k;
    logic [N-1:0]   cur_a, cur_b, mask;
    int             per_a[N], ph_a[N], per_b[N], ph_b[N];
    bit             term_edge;

    int           res       [2][N];
    logic [N-1:0] exp_ok    [2];
    logic [N-1:0] exp_sticky[2];
    logic         exp_valid [2];
    logic         exp_all   [2];
    int           exp_cnt   [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("a.meas_valid", 32'(ifa.meas_valid),     32'(exp_valid[0]));
        check_eq("a.clk_ok",     32'(ifa.clk_ok),         32'(exp_ok[0]));
        check_eq("a.sticky",     32'(ifa.clk_bad_sticky), 32'(exp_sticky[0]));
        check_eq("a.all_ok",     32'(ifa.all_ok),         32'(exp_all[0]));
        check_eq("a.cnt_out",    32'(ifa.cnt_out),        32'(exp_cnt[0]));
        check_eq("b.meas_valid", 32'(ifb.meas_valid),     32'(exp_valid[1]));
        check_eq("b.clk_ok",     32'(ifb.clk_ok),         32'(exp_ok[1]));
        check_eq("b.sticky",     32'(ifb.clk_bad_sticky), 32'(exp_sticky[1]));
        check_eq("b.all_ok",     32'(ifb.all_ok),         32'(exp_all[1]));
        check_eq("b.cnt_out",    32'(ifb.cnt_out),        32'(exp_cnt[1]));
    endtask

    function automatic logic hval(input int j, input int n, input int i);
        if (j < 0) return 1'b0;
        return hist[j][n*N + i];
    endfunction

    // A window closing at edge kt counts input transitions sampled at edges
    // kt-G-1 .. kt-2 (two edges of synchronizer delay before counting).
    function automatic int win_count(input int kt, input int n, input int i);
        int c = 0;
        for (int j = kt - G - 1; j <= kt - 2; j++) begin
            if (hval(j, n, i) != hval(j - 1, n, i)) c++;
        end
        return c;
    endfunction

    task automatic model_reset();
        hist.delete();
        k = 0;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < N; i++) res[n][i] = 0;
            exp_ok[n] = '0; exp_sticky[n] = '0; exp_valid[n] = 1'b0;
            exp_all[n] = 1'b0; exp_cnt[n] = 0;
        end
    endtask

    task automatic model_edge(input bit clr, input logic [4:0] s);
        logic [N-1:0] new_ok, set;
        int c;
        for (int n = 0; n < 2; n++) begin
            exp_cnt[n] = (int'(s) < N) ? res[n][s] : 0;
            exp_all[n] = &exp_ok[n];
            if ((k % G) == G - 1) begin
                exp_valid[n] = 1'b1;
                for (int i = 0; i < N; i++) begin
                    c = win_count(k, n, i);
                    if (c > sat[n]) c = sat[n];
                    res[n][i] = c;
                    new_ok[i] = mask[i] || (c >= lo[n] && c <= hi[n]);
                    set[i]    = !new_ok[i];
                end
                exp_sticky[n] = (clr ? '0 : exp_sticky[n]) | set;
                exp_ok[n]     = new_ok;
            end else begin
                exp_valid[n] = 1'b0;
                if (clr) exp_sticky[n] = '0;
            end
        end
    endtask

    task automatic drive(input bit clr);
        logic [N-1:0] xa, xb;
        logic [4:0]   s;
        xa = cur_a;
        xb = cur_b;
        for (int i = 0; i < N; i++) begin
            if (per_a[i] != 0 && ((k + ph_a[i]) % per_a[i]) == 0) xa[i] = ~xa[i];
            if (per_b[i] != 0 && ((k + ph_b[i]) % per_b[i]) == 0) xb[i] = ~xb[i];
        end
        // Extra transition whose edge is counted exactly on the terminal cycle.
        if (term_edge && (k % G) == G - 3) xa[3] = ~xa[3];
        s = 5'($urandom_range(31, 0));
        ifa.ref_tgl = xa;  ifb.ref_tgl = xb;
        ifa.sel = s;       ifb.sel = s;
        ifa.clear_sticky = clr;  ifb.clear_sticky = clr;
        ifa.ch_mask = mask;      ifb.ch_mask = mask;
        cur_a = xa;
        cur_b = xb;
        hist.push_back({xb, xa});
        model_edge(clr, s);
        k++;
    endtask

    task automatic cycle(input bit clr);
        @(negedge clk);
        check_outputs();
        drive(clr);
    endtask

    task automatic run_window(input int clr_at);
        for (int t = 0; t < G; t++) cycle(t == clr_at);
    endtask

    task automatic reset_phase(input int ncyc);
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        model_reset();
        repeat (ncyc) begin
            @(negedge clk);
            check_outputs();
        end
        rst = 1'b0;
        drive(1'b0);
    endtask

    int choices[7] = '{0, 2, 3, 4, 4, 4, 5};

    initial begin
        rst = 1'b1;
        mask = '0;
        cur_a = '0;
        cur_b = '0;
        term_edge = 1'b0;
        ifa.ref_tgl = '0; ifa.ch_mask = '0; ifa.clear_sticky = 1'b0; ifa.sel = '0;
        ifb.ref_tgl = '0; ifb.ch_mask = '0; ifb.clear_sticky = 1'b0; ifb.sel = '0;
        for (int i = 0; i < N; i++) begin
            per_a[i] = 4;
            ph_a[i]  = $urandom_range(3, 0);
            per_b[i] = (i == 0) ? 1 : 6;
            ph_b[i]  = $urandom_range(5, 0);
        end
        model_reset();
        reset_phase(4);

        run_window(-1);                         // all nominal
        per_a[5] = 0;
        run_window(-1);                         // ch5 stuck
        per_a[5] = 4; per_a[9] = 2; mask = 16'h0201;
        run_window(-1);                         // ch9 fast but masked
        mask = 16'h0001; per_a[5] = 0;
        run_window(G - 1);                      // clear collides with new faults
        per_a[5] = 4; per_a[9] = 4;
        run_window(500);                        // clear with no fault pending
        ph_a[3] = 0; term_edge = 1'b1;
        run_window(-1);                         // edge on terminal cycle
        term_edge = 1'b0;
        while ((k % G) != 600) cycle(1'b0);
        reset_phase(5);                         // reset mid-window

        for (int w = 0; w < 2; w++) begin
            mask = 16'($urandom) & 16'($urandom);
            for (int i = 1; i < N; i++) per_a[i] = choices[$urandom_range(6, 0)];
            run_window($urandom_range(G - 1, 0));
        end
        cycle(1'b0);
        cycle(1'b0);
        @(negedge clk);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/refclk_freq_monitor.md
Name: refclk_freq_monitor

Overview:
- Measures the rate of every GTH reference clock against the free-running 125 MHz fabric clock (`clk_125`).
- Flags each clock that is out of tolerance, with a live status and a sticky status.
- Sits directly downstream of the GTH reference-clock input buffers.
- Each buffered refclk (`rc[7:0]`, `arc[7:0]`) drives a small external divide-by-64 toggle flop in its own domain. This block sees only those toggle levels, as asynchronous inputs.
- Results feed the slow-control register file and link-bring-up logic.

Parameters:
- N_CLK, 16, number of monitored clocks (bit i: i<8 sync refclk `rc[i]`, i>=8 async refclk `arc[i-8]`).
- GATE_CYCLES, 125000, `clk` cycles per measurement window (1 ms at 125 MHz).
- CNT_W, 20, width of per-channel edge counter and result.
- EXP_MIN, 2495, lowest in-tolerance edge count per window.
- EXP_MAX, 2515, highest in-tolerance edge count per window.

Ports:
- clk  input  1  fabric clock; `clk_125`.
- rst  input  1  asynchronous, active-high reset.
- ref_tgl  input  N_CLK  divided-refclk toggle levels; asynchronous to `clk`.
- ch_mask  input  N_CLK  1 = channel ignored: forced ok, never sets sticky.
- clear_sticky  input  1  single-cycle pulse; clears `clk_bad_sticky`.
- sel  input  5  channel index for `cnt_out`.
- cnt_out  output  CNT_W  last completed window count of channel `sel`.
- meas_valid  output  1  one-cycle pulse; new results latched.
- clk_ok  output  N_CLK  per-channel in-tolerance status of last window.
- clk_bad_sticky  output  N_CLK  latched out-of-tolerance history.
- all_ok  output  1  AND of `clk_ok`.

Behaviour:
- Reset: all synchronizers, counters, results and outputs go to 0, including `clk_ok`, `all_ok`, `meas_valid`, `cnt_out` and `clk_bad_sticky`. Reset asserted mid-window abandons that window; no `meas_valid` is issued for it.
- Synchronizer, per channel:
  - 3-flop chain s1, s2, s3.
  - edge = s2 XOR s3; both toggle edges count.
  - Input-to-count latency is 3 cycles.
  - The first edge after reset may be spurious; it is absorbed by the first window.
- Edge counter, per channel:
  - Increments by 1 on edge.
  - Saturates at 2^CNT_W-1; no wrap.
- Gate counter:
  - Counts 0..GATE_CYCLES-1, then wraps.
  - The cycle with gate == GATE_CYCLES-1 is the terminal cycle.
- Terminal cycle:
  - result[i] <= live count including any edge in this cycle.
  - Live counters reset to 0.
  - An edge on the terminal cycle belongs to the closing window only.
- Cycle after terminal:
  - `meas_valid` = 1 for exactly one cycle.
  - clk_ok[i] = ch_mask[i] | (EXP_MIN <= result[i] <= EXP_MAX), registered.
- Same cycle as the `clk_ok` update:
  - For any unmasked channel out of range, `clk_bad_sticky[i]` sets.
  - Set has priority over a simultaneous `clear_sticky`.
  - `clear_sticky` in any other cycle clears all sticky bits on the next cycle.
- `all_ok`: registered AND of `clk_ok`, one cycle after `clk_ok` updates. It stays 0 until the first window completes.
- `cnt_out`:
  - Registered `result[sel]`, 1-cycle latency from a `sel` change or result update.
  - sel >= N_CLK gives 0.
- `ch_mask` is sampled only at compare time. Changing it mid-window affects only the next compare.
- Comparison arithmetic is unsigned on CNT_W bits. EXP_MIN <= EXP_MAX < 2^CNT_W is required and checked by an elaboration assertion.

Test Plan:
- Params GATE_CYCLES=1000, EXP_MIN=245, EXP_MAX=255. All 16 inputs toggle every 4 `clk` cycles (250 edges per window). Required: `meas_valid` at cycle 1000 after the first gate start; `clk_ok`=16'hFFFF; `all_ok`=1 one cycle later; sticky=0; `cnt_out`=250 for any sel<16.
- Channel 5 held constant. Required: result[5]=0, clk_ok[5]=0, clk_bad_sticky[5]=1, `all_ok`=0. Resume toggling on channel 5: next window clk_ok[5]=1, sticky stays 1 until `clear_sticky`.
- Channel 9 toggling every 2 cycles (500 edges) with ch_mask[9]=1. Required: clk_ok[9]=1, sticky[9]=0, cnt_out(sel=9)=500. Then set ch_mask[9]=0: next compare gives clk_ok[9]=0, sticky[9]=1.
- `clear_sticky` pulsed in the same cycle a new out-of-range result sets sticky[5]. Required: sticky[5]=1. Pulse again later with no fault: sticky goes to 0 one cycle after the pulse.
- Edge timed exactly on the terminal cycle. Required: counted in the closing window (251), next window starts from 0. Also assert `rst` at gate=600: all outputs 0, no `meas_valid`; the first new result arrives 1000 cycles after `rst` deasserts.
- CNT_W=8 with toggling every cycle (1000 edges). Required: result saturates at 255 and is out of range when EXP_MAX=200. Also sel=20 gives `cnt_out`=0.
